cfg_write_sched: RTL and testbench

CFG_WRITE_SCHED -- requirements
Module: cfg_write_sched

---
 rtl/cfg_write_sched.sv | 179 +++++++++++++++++
 tb/tb_cfg_write_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cfg_write_sched.sv
// Frame-synchronous register-write scheduler: two requesters queue writes, drained on FRAME_START.
// Optional CFG_DONE watchdog is enabled by defining CFG_SCHED_TIMEOUT_EN.

// Generic FIFO: wrap-around pointers with an extra lap bit.
// Latency: push visible at head on the next cycle; pop advances the head in the same cycle.
// Backpressure: caller must not push when full or pop when empty.
module cfg_sched_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_vld) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
endmodule

// Round-robin write arbiter + FIFO, drained onto the register bank once per frame, then kicks CFG_START.
// Latency: first WE_A one cycle after FRAME_START; CFG_START one cycle after the last write.
// Backpressure: ACK_x is combinational and drops while the FIFO is full; requesters hold until acked.
module cfg_write_sched #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic                          CLOCK,
    input  logic                          RESET_N,
    input  logic                          REQ_A,
    input  logic                          REQ_B,
    input  logic [2:0]                    ADDR_A,
    input  logic [2:0]                    ADDR_B,
    input  logic [7:0]                    DATA_A,
    input  logic [7:0]                    DATA_B,
    output logic                          ACK_A,
    output logic                          ACK_B,
    input  logic                          FRAME_START,
    output logic                          WE_A,
    output logic [2:0]                    ADD_A,
    output logic [7:0]                    DAT_A,
    output logic                          CFG_START,
    input  logic                          CFG_DONE,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   PENDING,
    output logic                          TIMEOUT_ERR
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, START, WAIT_DONE} state_t;

    state_t      state_q, state_d;
    logic        last_b_q;
    logic        grant_a, grant_b;
    logic        full, empty, push, pop;
    logic [10:0] push_dat, head_dat;
    logic [AW:0] remain_q;
    logic        tmo_hit;

    // Lone requester wins; on a tie the side not granted last wins.
    assign grant_a  = REQ_A & (~REQ_B | last_b_q);
    assign grant_b  = REQ_B & ~grant_a;
    assign ACK_A    = grant_a & ~full & RESET_N;
    assign ACK_B    = grant_b & ~full & RESET_N;
    assign push     = ACK_A | ACK_B;
    assign push_dat = ACK_A ? {ADDR_A, DATA_A} : {ADDR_B, DATA_B};

    cfg_sched_fifo #(.WIDTH(11), .DEPTH(FIFO_DEPTH)) u_fifo (
        .core_clk (CLOCK),
        .arst_n   (RESET_N),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (PENDING),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            remain_q <= '0;
            WE_A     <= 1'b0;
            ADD_A    <= '0;
            DAT_A    <= '0;
        end else begin
            state_q <= state_d;
            if (ACK_A)      last_b_q <= 1'b0;
            else if (ACK_B) last_b_q <= 1'b1;
            // remain_q counts writes still owed after the one being issued now.
            if (pop) remain_q <= (state_q == IDLE) ? PENDING - 1'b1 : remain_q - 1'b1;
            WE_A <= pop;
            if (pop) begin
                ADD_A <= head_dat[10:8];
                DAT_A <= head_dat[7:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        CFG_START = 1'b0;
        case (state_q)
            IDLE: begin
                if (FRAME_START && !empty) begin
                    pop     = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (remain_q != '0) pop = 1'b1;
                else                state_d = START;
            end
            START: begin
                CFG_START = 1'b1;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (CFG_DONE || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign BUSY = (state_q != IDLE);

`ifdef CFG_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_err_q;

    assign tmo_hit     = (state_q == WAIT_DONE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign TIMEOUT_ERR = tmo_err_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state_q == WAIT_DONE) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                      tmo_cnt_q <= '0;
            if (tmo_hit && !CFG_DONE) tmo_err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_cfg_write_sched.sv
// Directed bench for cfg_write_sched: a per-cycle vector table plus hand-written reset/drain/timeout sequences.
module tb_cfg_write_sched;
    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic       REQ_A, REQ_B;
    logic [2:0] ADDR_A, ADDR_B;
    logic [7:0] DATA_A, DATA_B;
    logic       ACK_A, ACK_B;
    logic       FRAME_START;
    logic       WE_A;
    logic [2:0] ADD_A;
    logic [7:0] DAT_A;
    logic       CFG_START;
    logic       CFG_DONE;
    logic       BUSY;
    logic [2:0] PENDING;
    logic       TIMEOUT_ERR;

    int checks = 0;
    int errors = 0;

    cfg_write_sched #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .REQ_A       (REQ_A),
        .REQ_B       (REQ_B),
        .ADDR_A      (ADDR_A),
        .ADDR_B      (ADDR_B),
        .DATA_A      (DATA_A),
        .DATA_B      (DATA_B),
        .ACK_A       (ACK_A),
        .ACK_B       (ACK_B),
        .FRAME_START (FRAME_START),
        .WE_A        (WE_A),
        .ADD_A       (ADD_A),
        .DAT_A       (DAT_A),
        .CFG_START   (CFG_START),
        .CFG_DONE    (CFG_DONE),
        .BUSY        (BUSY),
        .PENDING     (PENDING),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic       ra, rb;
        logic [2:0] aa; logic [7:0] da;
        logic [2:0] ab; logic [7:0] db;
        logic       fs, cd;
        logic       xa, xb, we;
        logic [2:0] add; logic [7:0] dat;
        logic       cs, busy;
        logic [2:0] pend;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        REQ_A = 0; REQ_B = 0; FRAME_START = 0; CFG_DONE = 0;
    endtask

    task automatic push_a(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLOCK);
        idle_inputs();
        REQ_A = 1; ADDR_A = a; DATA_A = d;
        #1 chk("push_ack_a", {31'd0, ACK_A}, 32'd1);
    endtask

    initial begin
        RESET_N = 0; idle_inputs();
        ADDR_A = 0; DATA_A = 0; ADDR_B = 0; DATA_B = 0;
        REQ_A = 1;
        #2;
        chk("rst_ack_a", {31'd0, ACK_A}, 32'd0);
        chk("rst_outs", {16'd0, WE_A, ADD_A, DAT_A, CFG_START, BUSY, TIMEOUT_ERR}, 32'd0);
        chk("rst_pending", {29'd0, PENDING}, 32'd0);
        REQ_A = 0;
        @(negedge CLOCK); RESET_N = 1;

        // ra rb aa da ab db fs cd | xa xb we add dat cs busy pend
        tbl.push_back('{1,1,3'd1,8'h11,3'd5,8'hBB,0,0, 1,0,0,3'd0,8'h00,0,0,3'd0});
        tbl.push_back('{1,1,3'd2,8'h22,3'd5,8'hBB,0,0, 0,1,0,3'd0,8'h00,0,0,3'd1});
        tbl.push_back('{1,1,3'd2,8'h22,3'd6,8'h66,0,0, 1,0,0,3'd0,8'h00,0,0,3'd2});
        tbl.push_back('{1,1,3'd3,8'h33,3'd6,8'h66,0,0, 0,1,0,3'd0,8'h00,0,0,3'd3});
        tbl.push_back('{1,1,3'd3,8'h33,3'd7,8'h77,0,0, 0,0,0,3'd0,8'h00,0,0,3'd4});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,1,0, 0,0,0,3'd0,8'h00,0,0,3'd4});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,0, 0,0,1,3'd1,8'h11,0,1,3'd3});
        tbl.push_back('{0,1,3'd0,8'h00,3'd0,8'hC3,0,0, 0,1,1,3'd5,8'hBB,0,1,3'd2});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,1,0, 0,0,1,3'd2,8'h22,0,1,3'd2});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,0, 0,0,1,3'd6,8'h66,0,1,3'd1});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,0, 0,0,0,3'd6,8'h66,1,1,3'd1});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,1,0, 0,0,0,3'd6,8'h66,0,1,3'd1});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,1, 0,0,0,3'd6,8'h66,0,1,3'd1});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,0, 0,0,0,3'd6,8'h66,0,0,3'd1});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,1,0, 0,0,0,3'd6,8'h66,0,0,3'd1});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,0, 0,0,1,3'd0,8'hC3,0,1,3'd0});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,0, 0,0,0,3'd0,8'hC3,1,1,3'd0});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,1, 0,0,0,3'd0,8'hC3,0,1,3'd0});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,1,0, 0,0,0,3'd0,8'hC3,0,0,3'd0});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,0, 0,0,0,3'd0,8'hC3,0,0,3'd0});
        tbl.push_back('{0,0,3'd0,8'h00,3'd0,8'h00,0,1, 0,0,0,3'd0,8'hC3,0,0,3'd0});

        foreach (tbl[i]) begin
            @(negedge CLOCK);
            REQ_A = tbl[i].ra; REQ_B = tbl[i].rb;
            ADDR_A = tbl[i].aa; DATA_A = tbl[i].da;
            ADDR_B = tbl[i].ab; DATA_B = tbl[i].db;
            FRAME_START = tbl[i].fs; CFG_DONE = tbl[i].cd;
            #1;
            chk($sformatf("vec%0d", i),
                {14'd0, ACK_A, ACK_B, WE_A, ADD_A, DAT_A, CFG_START, BUSY, PENDING},
                {14'd0, tbl[i].xa, tbl[i].xb, tbl[i].we, tbl[i].add, tbl[i].dat,
                 tbl[i].cs, tbl[i].busy, tbl[i].pend});
        end

        // Single write, then one frame.
        push_a(3'h2, 8'h5A);
        @(negedge CLOCK); idle_inputs(); FRAME_START = 1;
        #1 chk("single_pend_before", {29'd0, PENDING}, 32'd1);
        @(negedge CLOCK); idle_inputs();
        #1 chk("single_write", {20'd0, WE_A, ADD_A, DAT_A}, {20'd0, 1'b1, 3'h2, 8'h5A});
        chk("single_pend_after", {29'd0, PENDING}, 32'd0);
        @(negedge CLOCK);
        #1 chk("single_cfg_start", {30'd0, CFG_START, WE_A}, 32'b10);
        @(negedge CLOCK); CFG_DONE = 1;
        @(negedge CLOCK); CFG_DONE = 0;
        #1 chk("single_idle", {31'd0, BUSY}, 32'd0);

        // Reset asserted in the second of three drain cycles.
        push_a(3'h1, 8'hA1);
        push_a(3'h3, 8'hA3);
        push_a(3'h5, 8'hA5);
        @(negedge CLOCK); idle_inputs(); FRAME_START = 1;
        @(negedge CLOCK); idle_inputs();
        #1 chk("rstd_first_we", {20'd0, WE_A, ADD_A, DAT_A}, {20'd0, 1'b1, 3'h1, 8'hA1});
        @(negedge CLOCK);
        RESET_N = 0; REQ_A = 1;
        #1 chk("rstd_we_drop", {28'd0, WE_A, CFG_START, BUSY, ACK_A}, 32'd0);
        chk("rstd_pending", {29'd0, PENDING}, 32'd0);
        @(negedge CLOCK); RESET_N = 1; REQ_A = 0;
        @(negedge CLOCK); FRAME_START = 1;
        #1 chk("rstd_idle", {30'd0, BUSY, WE_A}, 32'd0);
        @(negedge CLOCK); FRAME_START = 0;
        #1 chk("rstd_no_drain", {29'd0, BUSY, WE_A, CFG_START}, 32'd0);

        // Missing CFG_DONE.
        push_a(3'h4, 8'h44);
        @(negedge CLOCK); idle_inputs(); FRAME_START = 1;
        @(negedge CLOCK); idle_inputs();
        @(negedge CLOCK);
        #1 chk("tmo_cfg_start", {31'd0, CFG_START}, 32'd1);
`ifdef CFG_SCHED_TIMEOUT_EN
        repeat (15) @(negedge CLOCK);
        #1 chk("tmo_still_busy", {30'd0, BUSY, TIMEOUT_ERR}, 32'b10);
        repeat (2) @(negedge CLOCK);
        #1 chk("tmo_expired", {30'd0, BUSY, TIMEOUT_ERR}, 32'b01);
`else
        repeat (40) @(negedge CLOCK);
        #1 chk("tmo_wait_forever", {30'd0, BUSY, TIMEOUT_ERR}, 32'b10);
        CFG_DONE = 1;
        @(negedge CLOCK); CFG_DONE = 0;
        #1 chk("tmo_done_idle", {31'd0, BUSY}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
